// File: rtl/mc_alu_pkg.sv
// rtl/mc_alu_pkg.sv - opcodes, FSM states and opcode helpers for mc_alu
package mc_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_XOR  = 4'h3;
  localparam logic [3:0] ALU_NOR  = 4'h4;
  localparam logic [3:0] ALU_SRL  = 4'h5;
  localparam logic [3:0] ALU_SUB  = 4'h6;
  localparam logic [3:0] ALU_SLTU = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_SLT  = 4'hA;
  localparam logic [3:0] ALU_MUL  = 4'hB;
  localparam logic [3:0] ALU_DIVU = 4'hC;
  localparam logic [3:0] ALU_REMU = 4'hD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mc_alu_iter_muldiv.sv
// rtl/mc_alu_iter_muldiv.sv - WIDTH-cycle shift-add multiplier / restoring divider on one adder
module mc_alu_iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mul,
  input  logic             rem,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] result
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  logic             busy;
  logic [SHW-1:0]   count;
  logic             is_mul;
  logic             is_rem;
  // MUL: acc=partial product, opa=multiplicand, opb=multiplier.
  // DIV: acc=partial remainder, opa=dividend shifting into quotient, opb=divisor.
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    shifted = {acc, opa[WIDTH-1]};
    if (is_mul) begin
      add_x = {1'b0, acc};
      add_y = opb[0] ? {1'b0, opa} : '0;
      cin   = 1'b0;
    end else begin
      add_x = shifted;
      add_y = ~{1'b0, opb};
      cin   = 1'b1;
    end
    sum = add_x + add_y + {{WIDTH{1'b0}}, cin};
    // A set top bit means the trial subtraction borrowed: keep the shifted remainder.
    rem_next = sum[WIDTH] ? shifted[WIDTH-1:0] : sum[WIDTH-1:0];
    quo_next = {opa[WIDTH-2:0], ~sum[WIDTH]};
    if (is_mul)      result = sum[WIDTH-1:0];
    else if (is_rem) result = rem_next;
    else             result = quo_next;
  end

  assign done = busy && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      is_mul <= 1'b0;
      is_rem <= 1'b0;
      dbz    <= 1'b0;
      acc    <= '0;
      opa    <= '0;
      opb    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      is_mul <= mul;
      is_rem <= rem;
      dbz    <= ~mul && (b == '0);
      acc    <= '0;
      opa    <= a;
      opb    <= b;
    end else if (busy) begin
      count <= count + 1'b1;
      if (count == LAST) busy <= 1'b0;
      if (is_mul) begin
        acc <= sum[WIDTH-1:0];
        opa <= {opa[WIDTH-2:0], 1'b0};
        opb <= {1'b0, opb[WIDTH-1:1]};
      end else begin
        acc <= rem_next;
        opa <= quo_next;
      end
    end
  end

endmodule

// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle valid/ready ALU; MC_ALU_MULDIV_EN enables iterative MUL/DIVU/REMU
module mc_alu
  import mc_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             overflow,
  output logic             dbz
);
  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  state_t           accept_target;
  logic             accept;
  logic             is_md;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             md_done;
  logic             md_dbz;
  logic [WIDTH-1:0] md_result;

  assign in_ready  = ~rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);

`ifdef MC_ALU_MULDIV_EN
  assign is_md = is_muldiv(op);

  mc_alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_md),
    .mul    (op == ALU_MUL),
    .rem    (op == ALU_REMU),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .dbz    (md_dbz),
    .result (md_result)
  );
`else
  assign is_md     = 1'b0;
  assign md_done   = 1'b0;
  assign md_dbz    = 1'b0;
  assign md_result = '0;
`endif

  always_comb begin
    sh      = b[SHW-1:0];
    sum_ab  = a + b;
    diff_ab = a - b;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      ALU_AND:  alu_res = a & b;
      ALU_OR:   alu_res = a | b;
      ALU_ADD: begin
        alu_res = sum_ab;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ab[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_XOR:  alu_res = a ^ b;
      ALU_NOR:  alu_res = ~(a | b);
      ALU_SRL:  alu_res = a >> sh;
      ALU_SUB: begin
        alu_res = diff_ab;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ab[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  alu_res = a << sh;
      ALU_SRA:  alu_res = $unsigned($signed(a) >>> sh);
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (is_md) accept_target = (op == ALU_MUL) ? S_MUL : S_DIV;
    else       accept_target = S_DONE;
    case (state)
      S_IDLE: if (accept) state_next = accept_target;
      S_MUL, S_DIV: if (md_done) state_next = S_DONE;
      S_DONE: begin
        if (accept)         state_next = accept_target;
        else if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      res      <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !is_md) begin
        res      <= alu_res;
        zero     <= (alu_res == '0);
        overflow <= alu_ovf;
        dbz      <= 1'b0;
      end else if (md_done) begin
        res      <= md_result;
        zero     <= (md_result == '0);
        overflow <= 1'b0;
        dbz      <= md_dbz;
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// tb/tb_mc_alu.sv - directed and randomized self-checking bench for mc_alu (WIDTH=32)
module tb_mc_alu;
  localparam int W = 32;
`ifdef MC_ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int MD_LAT = MD ? W + 1 : 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'h0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] res;
  logic         zero;
  logic         overflow;
  logic         dbz;

  int tests = 0;
  int failed = 0;

  mc_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .zero      (zero),
    .overflow  (overflow),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the opcode table, using plain integer arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned  sh;
    logic [63:0]  prod;
    logic [W-1:0] ones;
    sh   = int'(y % W);
    prod = 64'(x) * 64'(y);
    ones = '1;
    case (o)
      4'h0: return x & y;
      4'h1: return x | y;
      4'h2: return x + y;
      4'h3: return x ^ y;
      4'h4: return ~(x | y);
      4'h5: return x >> sh;
      4'h6: return x - y;
      4'h7: return (x < y) ? 1 : 0;
      4'h8: return x << sh;
      4'h9: return (x >> sh) | ((x[W-1] && sh != 0) ? ~(ones >> sh) : '0);
      4'hA: return (longint'(signed'(x)) < longint'(signed'(y))) ? 1 : 0;
      4'hB: return MD ? prod[W-1:0] : '0;
      4'hC: return MD ? ((y == 0) ? ones : x / y) : '0;
      4'hD: return MD ? ((y == 0) ? x : x % y) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint s;
    if (o == 4'h2)      s = longint'(signed'(x)) + longint'(signed'(y));
    else if (o == 4'h6) s = longint'(signed'(x)) - longint'(signed'(y));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [3:0] o);
    return (MD && (o == 4'hB || o == 4'hC || o == 4'hD)) ? MD_LAT : 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic eo, input logic ed, input int el);
    int wc;
    int cyc;
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    wc = 0;
    while (!in_ready && wc < 100) begin
      @(posedge clk); #1; wc++;
    end
    check({tag, ":in_ready"}, W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, ":latency"}, W'(cyc), W'(el));
    check({tag, ":res"}, res, er);
    check({tag, ":flags"}, {29'd0, zero, overflow, dbz}, {29'd0, (er == '0), eo, ed});
  endtask

  initial begin
    int seen;
    logic [3:0]   ro;
    logic [W-1:0] ra, rb, er;

    #1;
    check("rst:in_ready", W'(in_ready), 0);
    @(posedge clk); #1;
    check("rst:out_valid", W'(out_valid), 0);
    check("rst:res", res, 0);
    check("rst:flags", {29'd0, zero, overflow, dbz}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst:in_ready", W'(in_ready), 1);

    run_op("add_ovf",  4'h2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 1);
    run_op("sub_ovf",  4'h6, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 1);
    run_op("sra_mask", 4'h9, 32'hF0000000, 32'h24, 32'hFF000000, 1'b0, 1'b0, 1);
    run_op("slt",      4'hA, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
    run_op("sltu",     4'h7, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1);
    run_op("mul",      4'hB, 32'h0000FFFF, 32'h0000FFFF, MD ? 32'hFFFE0001 : 32'h0, 1'b0, 1'b0, MD_LAT);
    run_op("divu",     4'hC, 32'd100, 32'd7, MD ? 32'd14 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("remu",     4'hD, 32'd100, 32'd7, MD ? 32'd2 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("divu_dbz", 4'hC, 32'd5, 32'd0, MD ? 32'hFFFFFFFF : 32'h0, 1'b0, MD, MD_LAT);
    run_op("remu_dbz", 4'hD, 32'd5, 32'd0, MD ? 32'd5 : 32'h0, 1'b0, MD, MD_LAT);
    run_op("mul3x4",   4'hB, 32'd3, 32'd4, MD ? 32'd12 : 32'd0, 1'b0, 1'b0, MD_LAT);
    run_op("illegal",  4'hE, 32'hFFFF0000, 32'h1234, 32'h0, 1'b0, 1'b0, 1);

    // Back-pressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0; op = 4'h2; a = 32'h12345678; b = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0;
    check("bp:out_valid", W'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp:hold_res", res, 32'h12345679);
      check("bp:hold_ctl", {30'd0, out_valid, in_ready}, {30'd0, 1'b1, 1'b0});
    end
    op = 4'h6; a = 32'd10; b = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("bp:release_ready", W'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp:next_valid", W'(out_valid), 1);
    check("bp:next_res", res, 32'd7);
    @(posedge clk); #1;

    // Reset during a multiply iteration.
    op = 4'hB; a = 32'd3; b = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mul:out_valid", W'(out_valid), 0);
    check("rst_mul:in_ready", W'(in_ready), 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_mul:no_result", W'(seen), 0);
    run_op("add_after_rst", 4'h2, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      er = ref_res(ro, ra, rb);
      run_op($sformatf("rand%0d_op%h", i, ro), ro, ra, rb, er, ref_ovf(ro, ra, rb),
             MD && (ro == 4'hC || ro == 4'hD) && (rb == 0), ref_lat(ro));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
